buffer_w_wr_ctrl: RTL

Write sequencer that sits directly upstream of the west bridge buffer between the linear-projection stage and the Qn x KnT matmul. It accepts wide projection results over a valid/ready handshake and holds each beat stable. It then walks the slicing index across all TOTAL_MODULES module slices, generating one bank-0 Port-A write per slice into contiguous addresses. After a full frame it locks the bank until the downstream reader releases it.

---
 rtl/buffer_w_wr_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/buffer_w_wr_ctrl.sv
// Write sequencer for the west bridge buffer: holds each projection beat and
// writes its TOTAL_MODULES slices to contiguous bank-0 Port-A addresses, locking per frame.
package top_pkg;
   localparam int unsigned TOP_CHUNK_SIZE = 2;
endpackage

module buffer_w_wr_ctrl #(
   parameter  int unsigned WIDTH         = 16,
   parameter  int unsigned NUM_CORES_A   = 2,
   parameter  int unsigned NUM_CORES_B   = 1,
   parameter  int unsigned TOTAL_MODULES = 4,
   parameter  int unsigned TOTAL_INPUT_W = 2,
   parameter  int unsigned ROW_X         = 10,
   parameter  int unsigned COL_X         = 16,
   parameter  int unsigned NUM_WORDS     = 3,
   localparam int unsigned IN_WIDTH      = WIDTH * top_pkg::TOP_CHUNK_SIZE * NUM_CORES_A
                                           * NUM_CORES_B * TOTAL_MODULES,
   localparam int unsigned TOTAL_DEPTH   = ROW_X * COL_X,
   localparam int unsigned ADDR_WIDTH    = $clog2(TOTAL_DEPTH),
   localparam int unsigned IDX_W         = $clog2(TOTAL_MODULES)
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   input  logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0]  in_data,
   output logic                                    in_ready,
   input  logic                                    rd_release,
   output logic                                    bank0_ena,
   output logic                                    bank0_wea,
   output logic [ADDR_WIDTH-1:0]                   bank0_addra,
   output logic [IDX_W-1:0]                        slicing_idx,
   output logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0]  bank0_din,
   output logic                                    frame_done,
   output logic                                    buf_full
);

   localparam int unsigned BEAT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                                  state_q, state_d;
   logic [TOTAL_INPUT_W-1:0][IN_WIDTH-1:0]  hold_q, hold_d;
   logic [IDX_W-1:0]                        idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]                   wr_ptr_q, wr_ptr_d;
   logic [BEAT_W-1:0]                       beat_cnt_q, beat_cnt_d;
   logic                                    frame_done_q, frame_done_d;
   logic                                    ena_q, ena_d;
   logic                                    buf_full_q, buf_full_d;
   logic                                    last_slice;
   logic                                    last_beat;

   assign last_slice = (idx_q == IDX_W'(TOTAL_MODULES - 1));
   assign last_beat  = (beat_cnt_q == BEAT_W'(NUM_WORDS - 1));

   // Next-state, pointer walk and handshake decode
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      idx_d        = idx_q;
      wr_ptr_d     = wr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      frame_done_d = 1'b0;
      in_ready     = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_d  = in_data;
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            idx_d    = idx_q + IDX_W'(1);
            if (last_slice) begin
               idx_d = '0;
               if (last_beat) begin
                  state_d      = FULL;
                  wr_ptr_d     = '0;
                  beat_cnt_d   = '0;
                  frame_done_d = 1'b1;
               end else begin
                  // Overlap the next accept with the final slice so back-to-back beats have no bubble
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                  in_ready   = 1'b1;
                  if (in_valid) begin
                     hold_d = in_data;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         FULL: begin
            if (rd_release) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      ena_d      = (state_d == WRITE);
      buf_full_d = (state_d == FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         idx_q        <= '0;
         wr_ptr_q     <= '0;
         beat_cnt_q   <= '0;
         frame_done_q <= 1'b0;
         ena_q        <= 1'b0;
         buf_full_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         idx_q        <= idx_d;
         wr_ptr_q     <= wr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         frame_done_q <= frame_done_d;
         ena_q        <= ena_d;
         buf_full_q   <= buf_full_d;
      end
   end

   assign bank0_ena   = ena_q;
   assign bank0_wea   = ena_q;
   assign bank0_addra = wr_ptr_q;
   assign slicing_idx = idx_q;
   assign bank0_din   = hold_q;
   assign frame_done  = frame_done_q;
   assign buf_full    = buf_full_q;

endmodule
